// File: rtl/sim_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_sequencer_pkg
// Purpose  : Shared definitions for the simulation time-step sequencer. It
//            provides the sim_time width, the counter width, the FSM state
//            encodings and a helper that sizes the period timer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sim_sequencer_pkg;

  localparam int WIDTH_TIME    = 16;
  localparam int WIDTH_COUNTER = 12;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  // Bits needed to hold 0..period-1. The result is never less than 1, so a
  // two-cycle period still gets a real register.
  function automatic int timer_width(input int period);
    return (period <= 2) ? 1 : $clog2(period);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sim_sequencer_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : sim_sequencer_step_timer
// Purpose  : Period counter for one simulation time step. The count clears on
//            request, advances while enabled and saturates at LIMIT. The
//            expired flag is high while the count equals LIMIT.
// Ports    : clk     - system clock, rising edge
//            sta_n   - asynchronous active-low reset
//            clear   - synchronous clear to 0 (has priority over enable)
//            enable  - advance the count by one per cycle
//            expired - count == LIMIT
// Revision : 1.0 - initial release
// ============================================================================
module sim_sequencer_step_timer #(
  parameter int LIMIT = 7,
  parameter int WIDTH = 3
) (
  input  logic clk,
  input  logic sta_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge sta_n) begin
    if (!sta_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != C_LIMIT)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign expired = (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/sim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sim_sequencer
// Purpose  : Time-step sequencer for a cycle-based simulator. Each time step
//            lasts STEP_PERIOD clocks. During a step, N_STEPS sub-steps are
//            issued on counter. After the sub-steps, the sequencer waits for
//            the end of the period. A run ends at T_END, or at the step
//            boundary that follows a stop request.
// Ports    : clk        - system clock, rising edge
//            sta_n      - asynchronous active-low reset
//            start      - pulse that begins a run from idle
//            stop       - request to end the run at the next step boundary
//            hold       - freezes sub-step advance while running
//            counter    - sub-step index 1..N_STEPS, 0 otherwise
//            sim_time   - current time-step number, 1-based
//            step_start - high in the first cycle of each step
//            step_done  - high in the last cycle of each step
//            busy       - high whenever not idle
//            overrun    - sticky flag: sub-steps overran the step period
// Revision : 1.0 - initial release
// ============================================================================
module sim_sequencer
  import sim_sequencer_pkg::*;
#(
  parameter int N_STEPS     = 350,
  parameter int STEP_PERIOD = 400,
  parameter int T_END       = 0
) (
  input  logic                     clk,
  input  logic                     sta_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     hold,
  output logic [WIDTH_COUNTER-1:0] counter,
  output logic [WIDTH_TIME-1:0]    sim_time,
  output logic                     step_start,
  output logic                     step_done,
  output logic                     busy,
  output logic                     overrun
);

  localparam int                       TIMER_W   = timer_width(STEP_PERIOD);
  localparam logic [WIDTH_COUNTER-1:0] C_N_STEPS = WIDTH_COUNTER'(N_STEPS);
  localparam logic [WIDTH_TIME-1:0]    C_T_END   = WIDTH_TIME'(T_END);

  state_t r_state;
  logic   r_stop_pending;
  logic   w_expired;
  logic   w_run_done;
  logic   w_boundary;
  logic   w_last_step;
  logic   w_timer_clear;
  logic   w_timer_enable;

  // The boundary depends on hold in the current cycle. For that reason,
  // step_done is decoded from the registered state and hold instead of being
  // registered itself.
  always_comb begin
    w_run_done  = (r_state == ST_RUN) && !hold && (counter == C_N_STEPS);
    w_boundary  = w_expired && ((r_state == ST_WAIT) || w_run_done);
    // A stop seen in the boundary cycle itself also ends the run.
    w_last_step = r_stop_pending || stop ||
                  ((T_END != 0) && (sim_time == C_T_END));
    w_timer_clear  = (r_state == ST_IDLE) || w_boundary;
    w_timer_enable = (r_state != ST_IDLE);
  end

  sim_sequencer_step_timer #(
    .LIMIT (STEP_PERIOD - 1),
    .WIDTH (TIMER_W)
  ) u_step_timer (
    .clk     (clk),
    .sta_n   (sta_n),
    .clear   (w_timer_clear),
    .enable  (w_timer_enable),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge sta_n) begin
    if (!sta_n) begin
      r_state        <= ST_IDLE;
      r_stop_pending <= 1'b0;
      counter        <= '0;
      sim_time       <= '0;
      step_start     <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      step_start <= 1'b0;
      if ((r_state != ST_IDLE) && stop) begin
        r_stop_pending <= 1'b1;
      end

      if (w_boundary) begin
        if (w_last_step) begin
          r_state        <= ST_IDLE;
          counter        <= '0;
          r_stop_pending <= 1'b0;
        end else begin
          r_state    <= ST_RUN;
          counter    <= WIDTH_COUNTER'(1);
          sim_time   <= sim_time + WIDTH_TIME'(1);  // wraps silently
          step_start <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            counter        <= '0;
            r_stop_pending <= 1'b0;
            if (start) begin
              r_state    <= ST_RUN;
              counter    <= WIDTH_COUNTER'(1);
              sim_time   <= WIDTH_TIME'(1);
              step_start <= 1'b1;
              overrun    <= 1'b0;
            end
          end
          ST_RUN: begin
            // The period has ended, but the sub-steps have not finished.
            if (w_expired) begin
              overrun <= 1'b1;
            end
            if (!hold) begin
              if (counter < C_N_STEPS) begin
                counter <= counter + WIDTH_COUNTER'(1);
              end else begin
                counter <= '0;
                r_state <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
          end
          default: begin
            r_state <= ST_IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

  assign step_done = w_boundary;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
